// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   state_t        : conversion FSM states
//   DEF_*          : default parameter values for seg_scan_n
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_VALUE_W    = 14;
    localparam int DEF_DIV_BITS   = 16;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load bin and begin a conversion (VALUE_W steps follow)
//   bin          : binary input, sampled on start
//   done         : high during the cycle whose closing edge performs the
//                  last step; bcd/overflow are final from the next cycle on
//                  and hold until the next start
//   bcd          : NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
//   overflow     : input did not fit in NUM_DIGITS decimal digits
module bin2bcd_seq #(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               running;
    logic               ovf_q;

    // Add-3 correction on every digit that would exceed 9 after the shift.
    always_comb begin
        // NOTE: assign a default before any conditional update in always_comb
        // so every path drives the signal and no latch is inferred.
        adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            bin_sr  <= bin;
            bcd_sr  <= '0;
            cnt     <= '0;
            running <= 1'b1;
            ovf_q   <= 1'b0;
        end else if (running) begin
            bcd_sr <= {adj[BCD_W-2:0], bin_sr[VALUE_W-1]};
            bin_sr <= bin_sr << 1;
            // Any bit pushed out of the top digit means the value needs
            // one more decimal digit than we have.
            ovf_q  <= ovf_q | adj[BCD_W-1];
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(VALUE_W - 1))
                running <= 1'b0;
        end
    end

    assign done     = running && (cnt == CNT_W'(VALUE_W - 1));
    assign bcd      = bcd_sr;
    assign overflow = ovf_q;

endmodule

// File: rtl/seg_scan_n.sv
// Multiplexed seven-segment display scanner with hex or decimal display.
//   clk, reset_n : clock, asynchronous active-low reset
//   value        : binary value to show, captured on load
//   load         : one-cycle capture request, ignored while busy
//   dec_mode     : 1 = decimal via double-dabble, 0 = hexadecimal
//   blank_lz     : 1 = blank leading zero digits (digit 0 always shown)
//   digit        : index of the digit currently driven
//   disp_digit   : nibble of the current digit
//   disp_blank   : current digit is blanked
//   busy         : conversion in progress
//   ovf          : last committed decimal value did not fit
// The display registers change only in COMMIT, so a scan never shows a
// half-converted value. busy is registered and drops one cycle after COMMIT.
module seg_scan_n
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int VALUE_W    = DEF_VALUE_W,
    parameter int DIV_BITS   = DEF_DIV_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [VALUE_W-1:0]            value,
    input  logic                          load,
    input  logic                          dec_mode,
    input  logic                          blank_lz,
    output logic [$clog2(NUM_DIGITS)-1:0] digit,
    output logic [3:0]                    disp_digit,
    output logic                          disp_blank,
    output logic                          busy,
    output logic                          ovf
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    state_t              state;
    logic [VALUE_W-1:0]  value_q;
    logic                dec_q;
    logic                blank_lz_q;
    logic [BCD_W-1:0]    shadow;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [DIV_BITS-1:0] presc;

    logic                accept;
    logic                conv_start;
    logic                conv_done;
    logic [BCD_W-1:0]    conv_bcd;
    logic                conv_ovf;

    logic [BCD_W-1:0]      hex_nib;
    logic [BCD_W-1:0]      commit_nib;
    logic [NUM_DIGITS-1:0] commit_blank;
    logic                  commit_ovf;
    logic                  zero_above;

    assign accept     = (state == ST_IDLE) && !busy && load;
    assign conv_start = accept && dec_mode;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (conv_start),
        .bin      (value),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    // Next display contents, consumed only in COMMIT.
    always_comb begin
        hex_nib                = '0;
        hex_nib[VALUE_W-1:0]   = value_q;
        commit_ovf             = 1'b0;
        commit_nib             = hex_nib;
        if (dec_q) begin
            commit_ovf = conv_ovf;
            if (conv_ovf) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    commit_nib[4*i +: 4] = 4'd9;
            end else begin
                commit_nib = conv_bcd;
            end
        end

        // Walk down from the top digit; a digit blanks only while every
        // digit above it (and itself) is zero.
        commit_blank = '0;
        zero_above   = blank_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above      = zero_above && (commit_nib[4*i +: 4] == 4'd0);
            commit_blank[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the display shadow is reset because the display must read
        // all zeros after reset, before any commit.
        if (!reset_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            value_q    <= '0;
            dec_q      <= 1'b0;
            blank_lz_q <= 1'b0;
            shadow     <= '0;
            blank_mask <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        value_q    <= value;
                        dec_q      <= dec_mode;
                        blank_lz_q <= blank_lz;
                        busy       <= 1'b1;
                        state      <= dec_mode ? ST_CONV : ST_COMMIT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CONV: begin
                    if (conv_done)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    shadow     <= commit_nib;
                    blank_mask <= commit_blank;
                    ovf        <= commit_ovf;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Free-running prescaler; the digit steps when it wraps to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            digit <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (&presc)
                digit <= (digit == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
        end
    end

    always_comb begin
        disp_digit = shadow[4*digit +: 4];
        disp_blank = blank_mask[digit];
    end

endmodule

// File: doc/seg_scan_n.md
SEG_SCAN_N -- requirements
Module: seg_scan_n

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed 7-seg digits (range 2..8).
REQ-002 Parameter VALUE_W, default 14, width of the binary value input; SHALL satisfy VALUE_W <= 4*NUM_DIGITS.
REQ-003 Parameter DIV_BITS, default 16, width of the scan prescaler.
REQ-004 clk  in  1  system clock (50 MHz board clock).
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 value  in  VALUE_W  unsigned binary value to display.
REQ-007 load  in  1  single-cycle request to capture value.
REQ-008 dec_mode  in  1  1 = decimal (BCD) display, 0 = hexadecimal.
REQ-009 blank_lz  in  1  1 = blank leading zero digits.
REQ-010 digit  out  $clog2(NUM_DIGITS)  index of the digit currently driven (feeds the cathode decoder).
REQ-011 disp_digit  out  4  nibble for the current digit (feeds the segment decoder).
REQ-012 disp_blank  out  1  1 = current digit blanked.
REQ-013 busy  out  1  conversion in progress; load ignored while high.
REQ-014 ovf  out  1  last committed decimal value exceeded 10^NUM_DIGITS-1.

Function
REQ-015 FSM states IDLE, CONV, COMMIT; IDLE on reset.
REQ-016 IDLE: load=1 at edge k captures value, dec_mode, blank_lz; next state CONV if dec_mode=1, else COMMIT.
REQ-017 CONV: sequential double-dabble, one bit per cycle, exactly VALUE_W cycles, then COMMIT.
REQ-018 COMMIT: writes shadow display register, blank mask and ovf in one cycle, returns to IDLE.
REQ-019 busy SHALL be high whenever state != IDLE: hex mode, edges k+1..k+2; decimal mode, edges k+1..k+VALUE_W+2.
REQ-020 Display outputs update at edge k+2 (hex) or k+VALUE_W+2 (decimal); never mid-conversion (no tearing).
REQ-021 load while busy SHALL be ignored (no queueing, no state change).
REQ-022 Hex mode: digit i nibble = captured value bits [4i+3:4i], zero-extended; ovf cleared.
REQ-023 Decimal mode: value > 10^NUM_DIGITS-1 SHALL set ovf and commit all digits = 9; otherwise ovf cleared, digits = BCD of value.
REQ-024 Blank mask: digit i (i>=1) blanked iff captured blank_lz=1 and nibbles i..NUM_DIGITS-1 are all zero; digit 0 never blanked.
REQ-025 Prescaler: free-running DIV_BITS counter; digit advances by one when prescaler wraps from all-ones to zero.
REQ-026 digit wraps NUM_DIGITS-1 -> 0 (non-power-of-two counts supported).
REQ-027 disp_digit and disp_blank are combinational selects of shadow register and blank mask by digit.
REQ-028 Scanning continues uninterrupted during conversion.

Reset
REQ-029 reset_n low asynchronously forces: state IDLE, prescaler 0, digit 0, shadow register 0, blank mask 0, ovf 0, busy 0.
REQ-030 Reset asserted mid-conversion SHALL abandon the conversion; no partial commit after release.
REQ-031 After reset release the display shows all zeros, unblanked, until first commit.

Structure
REQ-032 Package seg_scan_pkg holds the FSM state enum and default parameter constants.
REQ-033 Double-dabble datapath SHALL be a sub-module bin2bcd_seq (start, done, VALUE_W in, 4*NUM_DIGITS out, overflow out).
REQ-034 Output interface compatible with existing 2-to-4 cathode decoder and hex segment decoder for NUM_DIGITS=4.

Verification (NUM_DIGITS=4, VALUE_W=14, DIV_BITS=4)
REQ-035 Hex: value=0x2A5F, dec_mode=0, load at edge k -> busy high edges k+1..k+2; digits 0..3 = F,5,A,2 from edge k+2; ovf=0.
REQ-036 Decimal: value=1234, dec_mode=1 -> busy 16 cycles, digits 0..3 = 4,3,2,1 at edge k+16; ovf=0.
REQ-037 Overflow: value=12000, dec_mode=1 -> all digits 9, ovf=1.
REQ-038 Blanking: value=7, dec_mode=1, blank_lz=1 -> digit0=7 unblanked, digits 1..3 disp_blank=1; value=0 -> only digit0 shown as 0.
REQ-039 Load during busy: second load with value=99 at edge k+5 of a decimal conversion of 1234 -> ignored, display 1234.
REQ-040 Reset mid-CONV at edge k+8 -> all outputs 0, digit scan restarts at 0 every 16 cycles, no commit of 1234.
